duck_round_tracker: RTL and testbench

//  Game-play bookkeeping that runs upstream of game_control_fsm and produces its game_finished input.

---
 rtl/duck_round_tracker_pkg.sv | 27 ++
 rtl/duck_round_tracker_if.sv | 27 ++
 rtl/duck_round_tracker_tick_prescaler.sv | 29 ++
 rtl/duck_round_tracker.sv | 156 +++++++++++++++
 tb/tb_duck_round_tracker.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/duck_round_tracker_pkg.sv
// Shared types and widths for the duck round bookkeeping logic.
package duck_round_tracker_pkg;

  localparam int SCORE_W = 16;
  localparam int CNT_W   = 8;
  localparam int SHOTS_W = 2;
  localparam int TIME_W  = 6;

  localparam int DEFAULT_POINTS_PER_HIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_PLAY,
    ST_RESOLVE,
    ST_FINISHED
  } state_t;

  // Score never wraps; it pins at all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/duck_round_tracker_if.sv
// Game-play signals between game control / detectors and the round tracker.
interface duck_round_tracker_if;
  import duck_round_tracker_pkg::*;

  logic               game_enable;
  logic               left_mouse;
  logic               duck_hit;
  logic               duck_escaped;
  logic               game_finished;
  logic               new_duck;
  logic [SCORE_W-1:0] score;
  logic [CNT_W-1:0]   ducks_hit;
  logic [CNT_W-1:0]   ducks_done;
  logic [SHOTS_W-1:0] shots_left;
  logic [TIME_W-1:0]  time_left;

  modport master (
    output game_enable, left_mouse, duck_hit, duck_escaped,
    input  game_finished, new_duck, score, ducks_hit, ducks_done, shots_left, time_left
  );

  modport slave (
    input  game_enable, left_mouse, duck_hit, duck_escaped,
    output game_finished, new_duck, score, ducks_hit, ducks_done, shots_left, time_left
  );

endinterface

// File: rtl/duck_round_tracker_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_1s
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_1s = en & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/duck_round_tracker.sv
// Round bookkeeping: shots, hits, duck count and round timer; flags end of game.
//
//  state       | meaning
//  ST_IDLE     | game not running, counters at reset values
//  ST_LAUNCH   | new_duck pulse, fresh shot allowance
//  ST_PLAY     | duck in flight, shots/hits/escape evaluated
//  ST_RESOLVE  | duck finished, decide next duck or game over
//  ST_FINISHED | game over, counters frozen for display
module duck_round_tracker
  import duck_round_tracker_pkg::*;
#(
  parameter int TICK_DIV       = 65_000_000,
  parameter int ROUND_TIME_S   = 60,
  parameter int SHOTS_PER_DUCK = 3,
  parameter int DUCKS_PER_GAME = 10,
  parameter int POINTS_PER_HIT = DEFAULT_POINTS_PER_HIT
) (
  input logic               clk,
  input logic               rst,
  duck_round_tracker_if.slave trk
);

  localparam logic [SHOTS_W-1:0] SHOTS_INIT = SHOTS_W'(SHOTS_PER_DUCK);
  localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(ROUND_TIME_S);
  localparam logic [CNT_W-1:0]   DUCKS_MAX  = CNT_W'(DUCKS_PER_GAME);
  localparam logic [SCORE_W-1:0] POINTS     = SCORE_W'(POINTS_PER_HIT);

  state_t             state;
  logic               left_mouse_q;
  logic               game_finished;
  logic               new_duck;
  logic [SCORE_W-1:0] score;
  logic [CNT_W-1:0]   ducks_hit;
  logic [CNT_W-1:0]   ducks_done;
  logic [SHOTS_W-1:0] shots_left;
  logic [TIME_W-1:0]  time_left;

  logic shot;
  logic expired;
  logic prescale_en;
  logic prescale_clr;
  logic tick_1s;

  assign shot         = trk.left_mouse & ~left_mouse_q;
  assign expired      = (time_left == '0);
  assign prescale_en  = (state == ST_LAUNCH) || (state == ST_PLAY) || (state == ST_RESOLVE);
  assign prescale_clr = (state == ST_IDLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (prescale_en),
    .clr     (prescale_clr),
    .tick_1s (tick_1s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      left_mouse_q  <= 1'b0;
      game_finished <= 1'b0;
      new_duck      <= 1'b0;
      score         <= '0;
      ducks_hit     <= '0;
      ducks_done    <= '0;
      shots_left    <= SHOTS_INIT;
      time_left     <= TIME_INIT;
    end else begin
      left_mouse_q <= trk.left_mouse;
      new_duck     <= 1'b0;

      if (!trk.game_enable) begin
        state         <= ST_IDLE;
        game_finished <= 1'b0;
        score         <= '0;
        ducks_hit     <= '0;
        ducks_done    <= '0;
        shots_left    <= SHOTS_INIT;
        time_left     <= TIME_INIT;
      end else begin
        if (tick_1s && !expired) begin
          time_left <= time_left - 1'b1;
        end

        case (state)
          ST_IDLE: begin
            state      <= ST_LAUNCH;
            new_duck   <= 1'b1;
            shots_left <= SHOTS_INIT;
          end

          ST_LAUNCH: begin
            if (expired) begin
              state         <= ST_FINISHED;
              game_finished <= 1'b1;
            end else begin
              state <= ST_PLAY;
            end
          end

          // Expiry beats hit beats miss beats escape.
          ST_PLAY: begin
            if (expired) begin
              state         <= ST_FINISHED;
              game_finished <= 1'b1;
            end else if (shot && trk.duck_hit) begin
              score      <= sat_add(score, POINTS);
              ducks_hit  <= ducks_hit + 1'b1;
              ducks_done <= ducks_done + 1'b1;
              state      <= ST_RESOLVE;
            end else if (shot) begin
              shots_left <= shots_left - 1'b1;
              if (shots_left == SHOTS_W'(1)) begin
                ducks_done <= ducks_done + 1'b1;
                state      <= ST_RESOLVE;
              end
            end else if (trk.duck_escaped) begin
              ducks_done <= ducks_done + 1'b1;
              state      <= ST_RESOLVE;
            end
          end

          ST_RESOLVE: begin
            if (expired || (ducks_done == DUCKS_MAX)) begin
              state         <= ST_FINISHED;
              game_finished <= 1'b1;
            end else begin
              state      <= ST_LAUNCH;
              new_duck   <= 1'b1;
              shots_left <= SHOTS_INIT;
            end
          end

          ST_FINISHED: begin
            game_finished <= 1'b1;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign trk.game_finished = game_finished;
  assign trk.new_duck      = new_duck;
  assign trk.score         = score;
  assign trk.ducks_hit     = ducks_hit;
  assign trk.ducks_done    = ducks_done;
  assign trk.shots_left    = shots_left;
  assign trk.time_left     = time_left;

endmodule

// File: tb/tb_duck_round_tracker.sv
// Directed bench for duck_round_tracker with a short round and two ducks.
module tb_duck_round_tracker;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  duck_round_tracker_if bus ();

  duck_round_tracker #(
    .TICK_DIV       (10),
    .ROUND_TIME_S   (5),
    .SHOTS_PER_DUCK (3),
    .DUCKS_PER_GAME (2),
    .POINTS_PER_HIT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .trk (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst              = 1'b1;
    bus.game_enable  = 1'b0;
    bus.left_mouse   = 1'b0;
    bus.duck_hit     = 1'b0;
    bus.duck_escaped = 1'b0;

    #2;
    chk("rst_score",      bus.score, 0);
    chk("rst_shots",      bus.shots_left, 3);
    chk("rst_time",       bus.time_left, 5);
    chk("rst_finished",   bus.game_finished, 0);
    chk("rst_new_duck",   bus.new_duck, 0);
    chk("rst_ducks_done", bus.ducks_done, 0);

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_new_duck", bus.new_duck, 0);

    // held button from the start click
    bus.left_mouse  = 1'b1;
    bus.game_enable = 1'b1;
    tick();
    chk("held_new_duck", bus.new_duck, 1);
    chk("held_shots",    bus.shots_left, 3);
    tick();
    chk("held_new_duck_drop", bus.new_duck, 0);
    tick();
    chk("held_no_shot",  bus.shots_left, 3);
    chk("held_no_done",  bus.ducks_done, 0);
    bus.left_mouse = 1'b0;
    tick();

    // hit
    bus.left_mouse = 1'b1;
    bus.duck_hit   = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    bus.duck_hit   = 1'b0;
    chk("hit_score",      bus.score, 10);
    chk("hit_ducks_hit",  bus.ducks_hit, 1);
    chk("hit_ducks_done", bus.ducks_done, 1);
    chk("hit_no_launch",  bus.new_duck, 0);
    tick();
    chk("hit_relaunch",   bus.new_duck, 1);
    chk("hit_shots",      bus.shots_left, 3);
    tick();
    chk("hit_pulse_once", bus.new_duck, 0);

    // three misses on the second duck
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("miss1_shots", bus.shots_left, 2);
    tick();
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("miss2_shots", bus.shots_left, 1);
    tick();
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("miss3_done",       bus.ducks_done, 2);
    chk("miss3_not_fin",    bus.game_finished, 0);
    chk("miss3_ducks_hit",  bus.ducks_hit, 1);
    tick();
    chk("game_over",        bus.game_finished, 1);
    chk("game_over_time",   bus.time_left, 4);
    repeat (3) tick();
    chk("frozen_finished",  bus.game_finished, 1);
    chk("frozen_score",     bus.score, 10);
    chk("frozen_done",      bus.ducks_done, 2);
    chk("frozen_new_duck",  bus.new_duck, 0);
    bus.game_enable = 1'b0;
    tick();
    chk("clear_finished",   bus.game_finished, 0);
    chk("clear_score",      bus.score, 0);
    chk("clear_ducks_hit",  bus.ducks_hit, 0);
    chk("clear_ducks_done", bus.ducks_done, 0);
    chk("clear_time",       bus.time_left, 5);
    chk("clear_shots",      bus.shots_left, 3);

    // timeout with no events
    bus.game_enable = 1'b1;
    tick();
    chk("to_launch", bus.new_duck, 1);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("to_time",     bus.time_left, 32'(5 - k / 10));
      chk("to_not_fin",  bus.game_finished, 0);
    end
    tick();
    chk("to_finished", bus.game_finished, 1);
    chk("to_time_0",   bus.time_left, 0);
    repeat (15) tick();
    chk("to_no_wrap",  bus.time_left, 0);
    chk("to_held",     bus.game_finished, 1);
    bus.game_enable = 1'b0;
    tick();
    chk("to_clear", bus.game_finished, 0);

    // hit and escape together
    bus.game_enable = 1'b1;
    tick();
    tick();
    bus.left_mouse   = 1'b1;
    bus.duck_hit     = 1'b1;
    bus.duck_escaped = 1'b1;
    tick();
    bus.left_mouse   = 1'b0;
    bus.duck_hit     = 1'b0;
    bus.duck_escaped = 1'b0;
    chk("coll_ducks_hit",  bus.ducks_hit, 1);
    chk("coll_ducks_done", bus.ducks_done, 1);
    chk("coll_score",      bus.score, 10);
    tick();
    chk("coll_relaunch",   bus.new_duck, 1);
    tick();

    // async reset mid-PLAY
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("pre_rst_shots", bus.shots_left, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_shots",      bus.shots_left, 3);
    chk("arst_score",      bus.score, 0);
    chk("arst_ducks_done", bus.ducks_done, 0);
    chk("arst_ducks_hit",  bus.ducks_hit, 0);
    chk("arst_time",       bus.time_left, 5);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_release_launch", bus.new_duck, 1);
    chk("arst_release_score",  bus.score, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
